// File: rtl/vbuf_skid_stage.sv
// Two-entry registered skid buffer in front of the VBUF chains; cuts the ready path.
// Optional output transfer counter enabled by defining VBUF_SKID_CNT_EN.
module vbuf_skid_stage #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef VBUF_SKID_CNT_EN
  ,
  output logic [CNT_W-1:0] xfer_cnt
`endif
);

  if (WIDTH < 1 || CNT_W < 1) begin : g_param_check
    $error("vbuf_skid_stage: WIDTH and CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_out_data;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] w_out_data_nxt;
  logic [WIDTH-1:0] w_skid_nxt;
  logic             r_out_valid;
  logic             r_in_ready;
  logic             w_in_fire;
  logic             w_out_fire;

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  // Next-state and next-data selection
  always_comb begin
    w_state_nxt    = r_state;
    w_out_data_nxt = r_out_data;
    w_skid_nxt     = r_skid;
    case (r_state)
      S_EMPTY: begin
        if (w_in_fire) begin
          w_state_nxt    = S_ONE;
          w_out_data_nxt = in_data;
        end
      end
      S_ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_out_data_nxt = in_data;
        end else if (w_in_fire) begin
          w_state_nxt = S_FULL;
          w_skid_nxt  = in_data;
        end else if (w_out_fire) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_FULL: begin
        if (w_out_fire) begin
          w_state_nxt    = S_ONE;
          w_out_data_nxt = r_skid;
        end
      end
      default: begin
        w_state_nxt = S_EMPTY;
      end
    endcase
  end

  // Handshake flags are registered decodes of the next state, so they never depend on inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_EMPTY;
      r_out_data  <= '0;
      r_skid      <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_out_data  <= w_out_data_nxt;
      r_skid      <= w_skid_nxt;
      r_out_valid <= (w_state_nxt != S_EMPTY);
      r_in_ready  <= (w_state_nxt != S_FULL);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

`ifdef VBUF_SKID_CNT_EN
  logic [CNT_W-1:0] r_xfer_cnt;

  // Free-running count of output transfers, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xfer_cnt <= '0;
    end else if (w_out_fire) begin
      r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
    end
  end

  assign xfer_cnt = r_xfer_cnt;
`endif

endmodule

// File: tb/tb_vbuf_skid_stage.sv
// Self-checking bench for vbuf_skid_stage: directed vector table, corner sequences,
// and randomized traffic against a two-entry queue model.
module tb_vbuf_skid_stage;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
`ifdef VBUF_SKID_CNT_EN
  logic [CNT_W-1:0] xfer_cnt;
`endif

  int checks;
  int errors;

  vbuf_skid_stage #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef VBUF_SKID_CNT_EN
    ,
    .xfer_cnt (xfer_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             iv;
    logic             ordy;
    logic [WIDTH-1:0] d;
    logic             e_ir;
    logic             e_ov;
    logic [WIDTH-1:0] e_od;
    logic             chk_od;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [WIDTH-1:0] q[$];
  int               xfers;
  logic             m_in_fire;
  logic             m_out_fire;

  initial begin
    checks = 0;
    errors = 0;

    // Each row: inputs applied for one edge, then expected outputs after it
    tbl[0]  = '{1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 8'h5A, 1'b0, 1'b1, 8'hA5, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 8'h5A, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 8'h11, 1'b1, 1'b1, 8'h11, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 8'h11, 1'b1, 1'b1, 8'h11, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 8'h22, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 8'h77, 1'b1, 1'b1, 8'h22, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 8'h00, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'd0);
`ifdef VBUF_SKID_CNT_EN
    chk("reset_xfer_cnt", 32'(xfer_cnt), 32'd0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      in_valid  = tbl[i].iv;
      out_ready = tbl[i].ordy;
      in_data   = tbl[i].d;
      step();
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      if (tbl[i].chk_od)
        chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(tbl[i].e_od));
    end

    // Streaming with no bubbles, then drain
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(i);
      step();
      chk($sformatf("stream%0d_out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("stream%0d_out_data", i), 32'(out_data), 32'(i));
      chk($sformatf("stream%0d_in_ready", i), 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("drain_out_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset while FULL
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    step();
    in_data = 8'h5A;
    step();
    chk("prereset_in_ready", 32'(in_ready), 32'd0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", 32'(out_valid), 32'd0);
    chk("midreset_out_data", 32'(out_data), 32'd0);
    chk("midreset_in_ready", 32'(in_ready), 32'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    chk("postreset_out_valid", 32'(out_valid), 32'd0);

`ifdef VBUF_SKID_CNT_EN
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(i);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("cnt_wrap_17", 32'(xfer_cnt), 32'd1);
`endif

    // Randomized traffic against a bounded-queue model
    do_reset();
    q.delete();
    xfers = 0;
    for (int n = 0; n < 2000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = WIDTH'($urandom);
      m_in_fire  = in_valid && (q.size() < 2);
      m_out_fire = out_ready && (q.size() > 0);
      step();
      if (m_out_fire) begin
        void'(q.pop_front());
        xfers++;
      end
      if (m_in_fire) q.push_back(in_data);
      chk("rnd_in_ready", 32'(in_ready), 32'(q.size() < 2));
      chk("rnd_out_valid", 32'(out_valid), 32'(q.size() > 0));
      if (q.size() > 0) chk("rnd_out_data", 32'(out_data), 32'(q[0]));
`ifdef VBUF_SKID_CNT_EN
      chk("rnd_xfer_cnt", 32'(xfer_cnt), 32'(CNT_W'(xfers)));
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
